// File: rtl/multiplexer_nway_reg_if.sv
// Handshake bundle for multiplexer_nway_reg: N input channels plus the registered output side.
// master = producers/consumer environment, slave = the mux itself.
interface multiplexer_nway_reg_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) ();

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/multiplexer_nway_reg.sv
// Registered N-channel mux with per-channel valid/ready and a single output holding register.
// Define MUX_RR_EN to compile in round-robin arbitration (mode=1); otherwise fixed select only.
module multiplexer_nway_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input logic                   clk,
  input logic                   rst,
  multiplexer_nway_reg_if.slave bus
);

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  logic                state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [SEL_W-1:0]    chan_q, chan_d;

  logic                load_en;
  logic                xfer;
  logic                fix_hit;
  logic                grant_hit;
  logic [SEL_W-1:0]    grant_idx;
  logic [WIDTH-1:0]    sel_data;
  logic [CHANNELS-1:0] ready;

  // Loop compare rather than direct indexing so an out-of-range sel never grants.
  always_comb begin
    fix_hit = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (SEL_W'(i) == bus.sel) fix_hit = bus.in_valid[i];
    end
  end

`ifdef MUX_RR_EN
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [CHANNELS-1:0] rot;
  logic                rr_hit;
  logic [SEL_W-1:0]    rr_idx;
  logic [SEL_W:0]      rr_sum;

  // Rotate valids so bit 0 is the channel at ptr; scanning downward leaves the first hit last.
  always_comb begin
    rot    = CHANNELS'({bus.in_valid, bus.in_valid} >> ptr_q);
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_sum = '0;
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        rr_hit = 1'b1;
        rr_sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
        if (rr_sum >= (SEL_W+1)'(CHANNELS)) rr_sum = rr_sum - (SEL_W+1)'(CHANNELS);
        rr_idx = rr_sum[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    grant_hit = bus.mode ? rr_hit : fix_hit;
    grant_idx = bus.mode ? rr_idx : bus.sel;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && bus.mode) begin
      ptr_d = (rr_idx == SEL_W'(CHANNELS - 1)) ? '0 : rr_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;

  always_comb begin
    grant_hit = fix_hit;
    grant_idx = bus.sel;
  end
`endif

  always_comb begin
    load_en = (state_q == StEmpty) || bus.out_ready;
    xfer    = load_en && grant_hit && !rst;
    ready   = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (xfer && (grant_idx == SEL_W'(i))) ready[i] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (grant_idx == SEL_W'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    if (xfer) begin
      state_d = StFull;
      data_d  = sel_data;
      chan_d  = grant_idx;
    end else if (bus.out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = (state_q == StFull);

endmodule

// File: tb/tb_multiplexer_nway_reg.sv
// Directed self-checking bench for multiplexer_nway_reg (WIDTH=8, CHANNELS=4).
// Round-robin steps are included only when MUX_RR_EN is defined.
module tb_multiplexer_nway_reg;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multiplexer_nway_reg_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) bus ();

  multiplexer_nway_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a valid request present: in_ready must stay low.
    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.sel       = 2'd0;
    bus.in_valid  = 4'b0001;
    bus.in_data   = 32'h0000_0055;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_chan", 32'(bus.out_chan), 32'h0);

    // Fixed select channel 2.
    rst          = 1'b0;
    bus.sel      = 2'd2;
    bus.in_valid = 4'b0100;
    bus.in_data  = 32'h00A5_0000;
    #1;
    chk("fix_in_ready", 32'(bus.in_ready), 32'h4);
    tick();
    chk("fix_out_valid", 32'(bus.out_valid), 32'h1);
    chk("fix_out_data", 32'(bus.out_data), 32'hA5);
    chk("fix_out_chan", 32'(bus.out_chan), 32'h2);

    // Back-pressure: held word stays, no new transfer.
    bus.out_ready = 1'b0;
    bus.in_data   = 32'h003C_0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      chk("bp_out_data", 32'(bus.out_data), 32'hA5);
      chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_in_ready", 32'(bus.in_ready), 32'h4);
    tick();
    chk("bp_rel_out_data", 32'(bus.out_data), 32'h3C);
    chk("bp_rel_out_chan", 32'(bus.out_chan), 32'h2);

    // Drain: FULL -> EMPTY with no transfer.
    bus.in_valid = 4'b0000;
    tick();
    chk("drain_out_valid", 32'(bus.out_valid), 32'h0);

    // Selected channel not valid: no transfer.
    bus.sel      = 2'd1;
    bus.in_valid = 4'b1101;
    bus.in_data  = 32'h7700_0011;
    #1;
    chk("nosel_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("nosel_out_valid", 32'(bus.out_valid), 32'h0);

    // Back-to-back fixed transfers: ch3 then ch0.
    bus.sel = 2'd3;
    tick();
    chk("b2b_ch3_data", 32'(bus.out_data), 32'h77);
    chk("b2b_ch3_chan", 32'(bus.out_chan), 32'h3);
    bus.sel = 2'd0;
    #1;
    chk("b2b_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("b2b_ch0_data", 32'(bus.out_data), 32'h11);
    chk("b2b_ch0_chan", 32'(bus.out_chan), 32'h0);
    chk("b2b_ch0_valid", 32'(bus.out_valid), 32'h1);

`ifdef MUX_RR_EN
    // Round-robin with all channels valid: 0,1,2,3,0 then 1,2 leaves ptr at 3.
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_data  = 32'h4433_2211;
    for (int n = 0; n < 7; n++) begin
      tick();
      chk("rr_out_chan", 32'(bus.out_chan), 32'(n % 4));
      chk("rr_out_data", 32'(bus.out_data), 32'(8'h11 * ((n % 4) + 1)));
    end
    // ptr=3, only ch1 valid: wrap to ch1, ptr becomes 2.
    bus.in_valid = 4'b0010;
    #1;
    chk("rr_wrap_in_ready", 32'(bus.in_ready), 32'h2);
    tick();
    chk("rr_wrap_out_chan", 32'(bus.out_chan), 32'h1);
    bus.in_valid = 4'b1111;
    #1;
    chk("rr_ptr2_in_ready", 32'(bus.in_ready), 32'h4);
`else
    // mode is ignored: fixed select still applies.
    bus.mode     = 1'b1;
    bus.sel      = 2'd2;
    bus.in_valid = 4'b1111;
    #1;
    chk("mode_ign_in_ready", 32'(bus.in_ready), 32'h4);
`endif

    // Reset overrides a simultaneous transfer on ch0.
    rst          = 1'b1;
    bus.mode     = 1'b0;
    bus.sel      = 2'd0;
    bus.in_valid = 4'b0001;
    #1;
    chk("rst2_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("rst2_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst2_out_data", 32'(bus.out_data), 32'h0);
    chk("rst2_out_chan", 32'(bus.out_chan), 32'h0);

    // After reset a mode=1 grant starts from channel 0.
    rst          = 1'b0;
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1111;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("post_rst_out_chan", 32'(bus.out_chan), 32'h0);
    chk("post_rst_out_data", 32'(bus.out_data), 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
